// File: rtl/layer_plan_pkg.sv
// Shared types for the layer tile planner.
//   layer_type_e : descriptor layer kinds (PW 1x1, CONV 3x3, DW 3x3, LINEAR)
//   plan_state_e : planner FSM states
//   KH_1X1/KH_3X3: kernel heights
//   layer_desc_t : latched layer descriptor
//   tile_plan_t  : registered plan presented on the output handshake
// Struct dimension fields are PLAN_DIM_W bits wide; the planner's DIM_W
// parameter is expected to match it.
package layer_plan_pkg;

  localparam int PLAN_DIM_W = 10;

  typedef enum logic [1:0] {
    LT_PW     = 2'd0,
    LT_CONV   = 2'd1,
    LT_DW     = 2'd2,
    LT_LINEAR = 2'd3
  } layer_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIM,
    ST_FOOT_I,
    ST_FOOT_W,
    ST_FOOT_P,
    ST_CHECK,
    ST_COUNT,
    ST_DONE
  } plan_state_e;

  localparam logic [1:0] KH_1X1 = 2'd1;
  localparam logic [1:0] KH_3X3 = 2'd3;

  typedef struct packed {
    logic [7:0]            layer_id;
    layer_type_e           ltype;
    logic [PLAN_DIM_W-1:0] in_r;
    logic [PLAN_DIM_W-1:0] in_c;
    logic [PLAN_DIM_W-1:0] in_d;
    logic [PLAN_DIM_W-1:0] out_k;
    logic [3:0]            stride;
    logic [3:0]            pad_t;
    logic [3:0]            pad_b;
    logic [3:0]            pad_l;
    logic [3:0]            pad_r;
  } layer_desc_t;

  typedef struct packed {
    logic                  err;
    logic [7:0]            layer_id;
    logic [PLAN_DIM_W-1:0] out_r;
    logic [PLAN_DIM_W-1:0] out_c;
    logic [PLAN_DIM_W-1:0] tile_r;
    logic [PLAN_DIM_W-1:0] out_tile_r;
    logic [PLAN_DIM_W-1:0] tile_d;
    logic [PLAN_DIM_W-1:0] tile_k;
    logic [PLAN_DIM_W-1:0] num_r;
    logic [PLAN_DIM_W-1:0] num_d;
    logic [PLAN_DIM_W-1:0] num_k;
    logic [31:0]           glb_bytes;
  } tile_plan_t;

  function automatic logic [1:0] kernel_height(input layer_type_e lt);
    return ((lt == LT_PW) || (lt == LT_LINEAR)) ? KH_1X1 : KH_3X3;
  endfunction

endpackage

// File: rtl/tile_div_ceil.sv
// Iterative ceil-division: one subtract-and-count step per enabled cycle.
//   clk      : clock
//   start    : load dividend into the remainder and clear the count
//   en       : take one step while the remainder is non-zero
//   dividend : value to be divided
//   divisor  : tile size (never 0)
//   count    : steps taken so far
//   done     : remainder has reached 0
//   last     : the next step (if any) empties the remainder
module tile_div_ceil #(
  parameter int DIM_W = 10
) (
  input  logic             clk,
  input  logic             start,
  input  logic             en,
  input  logic [DIM_W-1:0] dividend,
  input  logic [DIM_W-1:0] divisor,
  output logic [DIM_W-1:0] count,
  output logic             done,
  output logic             last
);

  logic [DIM_W-1:0] rem_q;
  logic [DIM_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (start) begin
      rem_q <= dividend;
      cnt_q <= '0;
    end else if (en && (rem_q != '0)) begin
      rem_q <= (rem_q > divisor) ? (rem_q - divisor) : '0;
      cnt_q <= cnt_q + DIM_W'(1);
    end
  end

  assign count = cnt_q;
  assign done  = (rem_q == '0);
  assign last  = (rem_q <= divisor);

endmodule

// File: rtl/layer_tile_planner.sv
// Layer tile planner: accepts one layer descriptor, derives the output map
// size, iteratively shrinks tiles until the ifmap+weight+psum footprint fits
// the global buffer, counts tiles per dimension and presents the plan.
//   clk, rst_n                 : clock, async active-low reset
//   cfg_valid_i / cfg_ready_o  : descriptor handshake (ready only in IDLE)
//   layer_id_i .. pad_R_i      : descriptor fields
//   plan_valid_o / plan_ready_i: plan handshake
//   plan_err_o                 : illegal descriptor or no tiling fits
//   layer_id_o .. glb_bytes_o  : plan fields, held until the next plan
module layer_tile_planner
  import layer_plan_pkg::*;
#(
  parameter int GLB_BYTES = 65536,
  parameter int BIT_A     = 8,
  parameter int BIT_W     = 8,
  parameter int BIT_P     = 16,
  parameter int DIM_W     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [7:0]       layer_id_i,
  input  logic [1:0]       layer_type_i,
  input  logic [DIM_W-1:0] in_R_i,
  input  logic [DIM_W-1:0] in_C_i,
  input  logic [DIM_W-1:0] in_D_i,
  input  logic [DIM_W-1:0] out_K_i,
  input  logic [3:0]       stride_i,
  input  logic [3:0]       pad_T_i,
  input  logic [3:0]       pad_B_i,
  input  logic [3:0]       pad_L_i,
  input  logic [3:0]       pad_R_i,
  output logic             plan_valid_o,
  input  logic             plan_ready_i,
  output logic             plan_err_o,
  output logic [7:0]       layer_id_o,
  output logic [DIM_W-1:0] out_R_o,
  output logic [DIM_W-1:0] out_C_o,
  output logic [DIM_W-1:0] tile_R_o,
  output logic [DIM_W-1:0] out_tile_R_o,
  output logic [DIM_W-1:0] tile_D_o,
  output logic [DIM_W-1:0] tile_K_o,
  output logic [DIM_W-1:0] num_tiles_R_o,
  output logic [DIM_W-1:0] num_tiles_D_o,
  output logic [DIM_W-1:0] num_tiles_K_o,
  output logic [31:0]      glb_bytes_o
);

  localparam int FW = 34;
  localparam logic [FW-1:0] BYTES_A   = FW'(BIT_A / 8);
  localparam logic [FW-1:0] BYTES_W   = FW'(BIT_W / 8);
  localparam logic [FW-1:0] BYTES_P   = FW'(BIT_P / 8);
  localparam logic [FW-1:0] GLB_LIMIT = FW'(GLB_BYTES);

  function automatic logic [DIM_W-1:0] ceil_half(input logic [DIM_W-1:0] x);
    return DIM_W'(({1'b0, x} + (DIM_W+1)'(1)) >> 1);
  endfunction

  plan_state_e state_q, state_d;
  layer_desc_t desc_q;
  tile_plan_t  plan_q;

  // Working registers of the search (data only, not reset).
  logic [1:0]       kh_q;
  logic             s2_q, dw_q;
  logic [DIM_W:0]   cp_q, tr_q;
  logic [DIM_W-1:0] out_r_q, out_c_q, in_d_q, k_div_q;
  logic [DIM_W-1:0] otr_q, td_q, tk_q;
  logic [FW-1:0]    foot_i_q, foot_w_q, foot_p_q;

  // Descriptor decode, evaluated in DIM.
  logic             is_lin, is_dw, s2, illegal;
  logic [DIM_W-1:0] eff_r, eff_c, d_in, k_out, out_r_calc, out_c_calc;
  logic [3:0]       eff_stride, p_t, p_b, p_l, p_r;
  logic [DIM_W:0]   kh_w, rp, cp;

  always_comb begin
    is_lin     = (desc_q.ltype == LT_LINEAR);
    is_dw      = (desc_q.ltype == LT_DW);
    eff_r      = is_lin ? DIM_W'(1) : DIM_W'(desc_q.in_r);
    eff_c      = is_lin ? DIM_W'(1) : DIM_W'(desc_q.in_c);
    d_in       = DIM_W'(desc_q.in_d);
    k_out      = DIM_W'(desc_q.out_k);
    eff_stride = is_lin ? 4'd1 : desc_q.stride;
    p_t        = is_lin ? 4'd0 : desc_q.pad_t;
    p_b        = is_lin ? 4'd0 : desc_q.pad_b;
    p_l        = is_lin ? 4'd0 : desc_q.pad_l;
    p_r        = is_lin ? 4'd0 : desc_q.pad_r;
    kh_w       = (DIM_W+1)'(kernel_height(desc_q.ltype));
    rp         = {1'b0, eff_r} + (DIM_W+1)'(p_t) + (DIM_W+1)'(p_b);
    cp         = {1'b0, eff_c} + (DIM_W+1)'(p_l) + (DIM_W+1)'(p_r);
    s2         = (eff_stride == 4'd2);
    out_r_calc = DIM_W'(((rp - kh_w) >> s2) + (DIM_W+1)'(1));
    out_c_calc = DIM_W'(((cp - kh_w) >> s2) + (DIM_W+1)'(1));
    illegal    = !((eff_stride == 4'd1) || (eff_stride == 4'd2)) ||
                 (eff_r == '0) || (eff_c == '0) || (d_in == '0) || (k_out == '0) ||
                 (rp < kh_w) || (cp < kh_w);
  end

  // Footprint terms and the fit decision.
  logic [DIM_W:0] tr_calc;
  logic [FW-1:0]  foot_i_calc, foot_w_calc, foot_p_calc, foot_sum;
  logic           fits, can_shrink;

  always_comb begin
    tr_calc     = ((DIM_W+1)'(otr_q - DIM_W'(1)) << s2_q) + (DIM_W+1)'(kh_q);
    foot_i_calc = FW'(tr_calc) * FW'(cp_q) * FW'(td_q) * BYTES_A;
    foot_w_calc = dw_q ? (FW'(td_q) * FW'(9) * BYTES_W)
                       : (FW'(tk_q) * FW'(td_q) * FW'(kh_q) * FW'(kh_q) * BYTES_W);
    foot_p_calc = FW'(otr_q) * FW'(out_c_q) * FW'(tk_q) * BYTES_P;
    foot_sum    = foot_i_q + foot_w_q + foot_p_q;
    fits        = (foot_sum <= GLB_LIMIT);
    can_shrink  = (otr_q > DIM_W'(1)) || (td_q > DIM_W'(1)) ||
                  (!dw_q && (tk_q > DIM_W'(1)));
  end

  // Tile counters, run in parallel during COUNT.
  logic             div_start, div_en, count_last;
  logic [DIM_W-1:0] cnt_r, cnt_d, cnt_k;
  logic             done_r, done_d, done_k, last_r, last_d, last_k;

  tile_div_ceil #(.DIM_W(DIM_W)) u_div_r (
    .clk(clk), .start(div_start), .en(div_en), .dividend(out_r_q), .divisor(otr_q),
    .count(cnt_r), .done(done_r), .last(last_r));
  tile_div_ceil #(.DIM_W(DIM_W)) u_div_d (
    .clk(clk), .start(div_start), .en(div_en), .dividend(in_d_q), .divisor(td_q),
    .count(cnt_d), .done(done_d), .last(last_d));
  tile_div_ceil #(.DIM_W(DIM_W)) u_div_k (
    .clk(clk), .start(div_start), .en(div_en), .dividend(k_div_q), .divisor(tk_q),
    .count(cnt_k), .done(done_k), .last(last_k));

  assign count_last = last_r && last_d && last_k;

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (cfg_valid_i) state_d = ST_DIM;
      ST_DIM:    state_d = illegal ? ST_DONE : ST_FOOT_I;
      ST_FOOT_I: state_d = ST_FOOT_W;
      ST_FOOT_W: state_d = ST_FOOT_P;
      ST_FOOT_P: state_d = ST_CHECK;
      ST_CHECK:  state_d = fits ? ST_COUNT : (can_shrink ? ST_FOOT_I : ST_DONE);
      ST_COUNT:  if (count_last) state_d = ST_DONE;
      ST_DONE:   if (plan_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs and datapath strobes.
  always_comb begin
    cfg_ready_o  = (state_q == ST_IDLE);
    plan_valid_o = (state_q == ST_DONE);
    div_start    = (state_q == ST_CHECK) && fits;
    div_en       = (state_q == ST_COUNT);
  end

  // Search datapath: descriptor latch, dimension setup, footprints, shrink.
  always_ff @(posedge clk) begin
    unique case (state_q)
      ST_IDLE: if (cfg_valid_i) begin
        desc_q <= '{layer_id: layer_id_i, ltype: layer_type_e'(layer_type_i),
                    in_r: PLAN_DIM_W'(in_R_i), in_c: PLAN_DIM_W'(in_C_i),
                    in_d: PLAN_DIM_W'(in_D_i), out_k: PLAN_DIM_W'(out_K_i),
                    stride: stride_i, pad_t: pad_T_i, pad_b: pad_B_i,
                    pad_l: pad_L_i, pad_r: pad_R_i};
      end
      ST_DIM: begin
        kh_q    <= kernel_height(desc_q.ltype);
        s2_q    <= s2;
        dw_q    <= is_dw;
        cp_q    <= cp;
        out_r_q <= out_r_calc;
        out_c_q <= out_c_calc;
        in_d_q  <= d_in;
        // Depthwise channel tiles follow the input channels, so K counts as D.
        k_div_q <= is_dw ? d_in : k_out;
        otr_q   <= out_r_calc;
        td_q    <= d_in;
        tk_q    <= is_dw ? d_in : k_out;
      end
      ST_FOOT_I: begin
        tr_q     <= tr_calc;
        foot_i_q <= foot_i_calc;
      end
      ST_FOOT_W: foot_w_q <= foot_w_calc;
      ST_FOOT_P: foot_p_q <= foot_p_calc;
      ST_CHECK: if (!fits) begin
        // Shrink rows first, then input channels, then output channels.
        if (otr_q > DIM_W'(1)) begin
          otr_q <= ceil_half(otr_q);
        end else if (td_q > DIM_W'(1)) begin
          td_q <= ceil_half(td_q);
          if (dw_q) tk_q <= ceil_half(td_q);
        end else if (!dw_q && (tk_q > DIM_W'(1))) begin
          tk_q <= ceil_half(tk_q);
        end
      end
      default: ;
    endcase
  end

  // Plan register: written once per descriptor, held through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plan_q <= '0;
    end else begin
      unique case (state_q)
        ST_DIM: if (illegal) begin
          plan_q          <= '0;
          plan_q.err      <= 1'b1;
          plan_q.layer_id <= desc_q.layer_id;
        end
        ST_CHECK: if (!fits && !can_shrink) begin
          plan_q          <= '0;
          plan_q.err      <= 1'b1;
          plan_q.layer_id <= desc_q.layer_id;
          plan_q.out_r    <= PLAN_DIM_W'(out_r_q);
          plan_q.out_c    <= PLAN_DIM_W'(out_c_q);
        end
        ST_COUNT: if (count_last) begin
          // Counters take their final step on this same edge.
          plan_q.err        <= 1'b0;
          plan_q.layer_id   <= desc_q.layer_id;
          plan_q.out_r      <= PLAN_DIM_W'(out_r_q);
          plan_q.out_c      <= PLAN_DIM_W'(out_c_q);
          plan_q.tile_r     <= PLAN_DIM_W'(tr_q);
          plan_q.out_tile_r <= PLAN_DIM_W'(otr_q);
          plan_q.tile_d     <= PLAN_DIM_W'(td_q);
          plan_q.tile_k     <= PLAN_DIM_W'(tk_q);
          plan_q.num_r      <= PLAN_DIM_W'(cnt_r + DIM_W'(!done_r));
          plan_q.num_d      <= PLAN_DIM_W'(cnt_d + DIM_W'(!done_d));
          plan_q.num_k      <= PLAN_DIM_W'(cnt_k + DIM_W'(!done_k));
          plan_q.glb_bytes  <= foot_sum[31:0];
        end
        default: ;
      endcase
    end
  end

  assign plan_err_o    = plan_q.err;
  assign layer_id_o    = plan_q.layer_id;
  assign out_R_o       = DIM_W'(plan_q.out_r);
  assign out_C_o       = DIM_W'(plan_q.out_c);
  assign tile_R_o      = DIM_W'(plan_q.tile_r);
  assign out_tile_R_o  = DIM_W'(plan_q.out_tile_r);
  assign tile_D_o      = DIM_W'(plan_q.tile_d);
  assign tile_K_o      = DIM_W'(plan_q.tile_k);
  assign num_tiles_R_o = DIM_W'(plan_q.num_r);
  assign num_tiles_D_o = DIM_W'(plan_q.num_d);
  assign num_tiles_K_o = DIM_W'(plan_q.num_k);
  assign glb_bytes_o   = plan_q.glb_bytes;

endmodule
